// File: rtl/orb_ram_wr_arbiter_if.sv
// Bus bundle between the telemetry packers (master side) and the
// orbital-frame RAM write arbiter (slave side).
//   req/reqAddr/reqData : per-requester write request, packed address/data
//   SW                  : asynchronous frame-switch toggle
//   ack                 : one-cycle completion pulse, one-hot
//   ramWE/ramAddr/ramData : RAM write port
//   bank/swapPulse      : active buffer bank and its toggle strobe
//   dropCnt             : saturating count of discarded address-0 writes
interface orb_ram_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 11,
  parameter int DW   = 12
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] reqAddr;
  logic [NREQ*DW-1:0] reqData;
  logic               SW;
  logic [NREQ-1:0]    ack;
  logic               ramWE;
  logic [AW-1:0]      ramAddr;
  logic [DW-1:0]      ramData;
  logic               bank;
  logic               swapPulse;
  logic [7:0]         dropCnt;

  modport master (
    output req, reqAddr, reqData, SW,
    input  ack, ramWE, ramAddr, ramData, bank, swapPulse, dropCnt
  );

  modport slave (
    input  req, reqAddr, reqData, SW,
    output ack, ramWE, ramAddr, ramData, bank, swapPulse, dropCnt
  );
endinterface

// File: rtl/orb_ram_wr_arbiter.sv
// Round-robin arbiter for the single write port of the orbital-frame RAM.
// Each granted write runs setup -> WE pulse -> ack; writes to address 0
// (frame-header slot) are discarded and counted. Owns the double-buffer
// bank bit, flipped on a synchronized SW change, only between transactions.
// Ports:
//   clk  : system clock, posedge
//   rst  : asynchronous reset, active low
//   bus  : slave modport of orb_ram_wr_arbiter_if (requests, RAM port,
//          bank/swapPulse, dropCnt)
module orb_ram_wr_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 11,
  parameter int DW     = 12,
  parameter int SETUP  = 1,
  parameter int WE_LEN = 2
) (
  input logic                 clk,
  input logic                 rst,
  orb_ram_wr_arbiter_if.slave bus
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SETUP > WE_LEN) ? SETUP : WE_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_DROP, S_DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr, g, pick;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            sw_s1, sw_s2, sw_prev, swap_pend, sw_change;
  logic [NREQ-1:0] ack;
  logic            ram_we, bank, swap_pulse;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic [7:0]      drop_cnt;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.reqAddr[i*AW +: AW];
    assign data_arr[i] = bus.reqData[i*DW +: DW];
  end

  // Search ptr+1, ptr+2, ... ; iterate farthest-first so the nearest hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req[PW'(idx)]) begin
        any_req = 1'b1;
        pick    = PW'(idx);
      end
    end
  end

  assign sw_change = sw_s2 ^ sw_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= PW'(NREQ - 1);
      g          <= '0;
      cnt        <= '0;
      ack        <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      bank       <= 1'b0;
      swap_pulse <= 1'b0;
      drop_cnt   <= '0;
      sw_s1      <= 1'b0;
      sw_s2      <= 1'b0;
      sw_prev    <= 1'b0;
      swap_pend  <= 1'b0;
    end else begin
      sw_s1      <= bus.SW;
      sw_s2      <= sw_s1;
      sw_prev    <= sw_s2;
      swap_pend  <= swap_pend | sw_change;
      swap_pulse <= 1'b0;
      ack        <= '0;
      case (state)
        S_IDLE: begin
          if (swap_pend) begin
            // A change landing on the clearing cycle starts a new pending swap.
            bank       <= ~bank;
            swap_pulse <= 1'b1;
            swap_pend  <= sw_change;
          end else if (any_req) begin
            g        <= pick;
            ram_addr <= addr_arr[pick];
            ram_data <= data_arr[pick];
            cnt      <= '0;
            state    <= (addr_arr[pick] != '0) ? S_SETUP : S_DROP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(SETUP - 1)) begin
            cnt    <= '0;
            ram_we <= 1'b1;
            state  <= S_WRITE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          if (cnt == CW'(WE_LEN - 1)) begin
            ram_we <= 1'b0;
            ack    <= NREQ'(1) << g;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DROP: begin
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          ack   <= NREQ'(1) << g;
          state <= S_DONE;
        end
        S_DONE: begin
          ptr   <= g;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack;
  assign bus.ramWE     = ram_we;
  assign bus.ramAddr   = ram_addr;
  assign bus.ramData   = ram_data;
  assign bus.bank      = bank;
  assign bus.swapPulse = swap_pulse;
  assign bus.dropCnt   = drop_cnt;
endmodule

// File: tb/tb_orb_ram_wr_arbiter.sv
// Bench for orb_ram_wr_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level round-robin model.
module tb_orb_ram_wr_arbiter;
  localparam int NREQ = 3, AW = 11, DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  orb_ram_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

  orb_ram_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SETUP(1), .WE_LEN(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.reqAddr[i*AW +: AW] = a;
    bus.reqData[i*DW +: DW] = d;
    bus.req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.SW = 1'b0;
    nclk(2);
    rst = 1'b1;
    nclk(1);
  endtask

  task automatic wait_ack(input int lim, output logic [NREQ-1:0] a);
    a = '0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // Model: first set bit of the request mask after the last winner, cyclic.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  logic [NREQ-1:0] a;
  logic [NREQ-1:0] hist [64];
  logic [AW-1:0]   ah [NREQ];
  logic [DW-1:0]   dh [NREQ];
  logic [AW-1:0]   we_a;
  logic [DW-1:0]   we_d;
  int last, drops, we_cnt, acks, ai, lat, bad, k4;

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.reqAddr = '0; bus.reqData = '0; bus.SW = 1'b0;
    nclk(2);
    chk("rst_we",   32'(bus.ramWE), 32'd0);
    chk("rst_ack",  32'(bus.ack), 32'd0);
    chk("rst_bank", 32'(bus.bank), 32'd0);
    chk("rst_drop", 32'(bus.dropCnt), 32'd0);
    chk("rst_addr", 32'(bus.ramAddr), 32'd0);
    rst = 1'b1;
    nclk(1);

    // basic write timing
    set_req(0, 11'h123, 12'hABC);
    nclk(1);
    chk("t1_addr", 32'(bus.ramAddr), 32'h123);
    chk("t1_data", 32'(bus.ramData), 32'hABC);
    chk("t1_we_c1", 32'(bus.ramWE), 32'd0);
    nclk(1);
    chk("t1_we_c2", 32'(bus.ramWE), 32'd1);
    chk("t1_ack_c2", 32'(bus.ack), 32'd0);
    nclk(1);
    chk("t1_we_c3", 32'(bus.ramWE), 32'd1);
    nclk(1);
    chk("t1_ack_c4", 32'(bus.ack), 32'b001);
    chk("t1_we_c4", 32'(bus.ramWE), 32'd0);
    bus.req[0] = 1'b0;
    nclk(1);
    chk("t1_noack", 32'(bus.ack), 32'd0);

    // data sampled only at grant, deassert mid-transaction
    set_req(0, 11'h055, 12'h321);
    nclk(1);
    chk("t6_data_c1", 32'(bus.ramData), 32'h321);
    bus.reqData[0 +: DW] = 12'hFFF;
    bus.req[0] = 1'b0;
    nclk(1);
    chk("t6_we", 32'(bus.ramWE), 32'd1);
    chk("t6_data_c2", 32'(bus.ramData), 32'h321);
    nclk(2);
    chk("t6_ack", 32'(bus.ack), 32'b001);
    chk("t6_data_c4", 32'(bus.ramData), 32'h321);
    nclk(1);
    chk("t6_noack", 32'(bus.ack), 32'd0);

    // address 0 is dropped
    set_req(1, 11'h000, 12'h777);
    nclk(1);
    chk("t3_we_c1", 32'(bus.ramWE), 32'd0);
    nclk(1);
    chk("t3_ack", 32'(bus.ack), 32'b010);
    chk("t3_we_c2", 32'(bus.ramWE), 32'd0);
    chk("t3_drop1", 32'(bus.dropCnt), 32'd1);
    bus.req[1] = 1'b0;
    nclk(1);
    bad = 0;
    for (int i = 0; i < 299; i++) begin
      set_req(1, 11'h000, DW'(i));
      wait_ack(8, a);
      if (a != 3'b010) bad++;
      bus.req[1] = 1'b0;
    end
    chk("t3_drop_acks", 32'(bad), 32'd0);
    chk("t3_sat", 32'(bus.dropCnt), 32'd255);

    // fair round robin with all requesters held
    do_reset();
    set_req(0, 11'h101, 12'h001);
    set_req(1, 11'h102, 12'h002);
    set_req(2, 11'h103, 12'h003);
    for (int k = 0; k < 6; k++) begin
      wait_ack(12, a);
      chk("t2_order", 32'(a), 32'd1 << (k % 3));
    end
    bus.req = '0;
    nclk(3);

    // SW toggle mid-write, swap after DONE, then pending req1
    do_reset();
    set_req(0, 11'h200, 12'h111);
    nclk(2);
    bus.SW = 1'b1;
    set_req(1, 11'h300, 12'h222);
    wait_ack(8, a);
    chk("t4_ack0", 32'(a), 32'b001);
    chk("t4_bank_pre", 32'(bus.bank), 32'd0);
    bus.req[0] = 1'b0;
    k4 = 4;
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      if (bus.swapPulse) begin k4 = k; break; end
    end
    chk("t4_swap_delay", 32'(k4), 32'd1);
    chk("t4_bank", 32'(bus.bank), 32'd1);
    nclk(1);
    chk("t4_grant1", 32'(bus.ramAddr), 32'h300);
    chk("t4_pulse_once", 32'(bus.swapPulse), 32'd0);
    wait_ack(8, a);
    chk("t4_ack1", 32'(a), 32'b010);
    bus.req = '0;
    nclk(1);

    // reset mid-write
    set_req(0, 11'h010, 12'h5A5);
    nclk(2);
    chk("t5_we_pre", 32'(bus.ramWE), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_we", 32'(bus.ramWE), 32'd0);
    chk("t5_ack", 32'(bus.ack), 32'd0);
    chk("t5_bank", 32'(bus.bank), 32'd0);
    bus.req = '0;
    bus.SW = 1'b0;
    nclk(1);
    rst = 1'b1;
    set_req(0, 11'h011, 12'h001);
    set_req(1, 11'h012, 12'h002);
    wait_ack(12, a);
    chk("t5_first", 32'(a), 32'b001);
    bus.req[0] = 1'b0;
    wait_ack(12, a);
    chk("t5_second", 32'(a), 32'b010);
    bus.req = '0;

    // randomized run against the transaction model
    do_reset();
    last = NREQ - 1; drops = 0; we_cnt = 0; acks = 0;
    for (int i = 0; i < 64; i++) hist[i] = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bus.ramWE) begin
        we_cnt++;
        we_a = bus.ramAddr;
        we_d = bus.ramData;
      end
      if (bus.ack != '0) begin
        chk("rnd_onehot", 32'($onehot(bus.ack)), 32'd1);
        ai = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (bus.ack[i]) ai = i;
        lat = (ah[ai] == '0) ? 2 : 4;
        chk("rnd_winner", 32'(ai), 32'(rr_pick(hist[(cyc - lat) % 64], last)));
        chk("rnd_we_len", 32'(we_cnt), (ah[ai] == '0) ? 32'd0 : 32'd2);
        if (ah[ai] != '0) begin
          chk("rnd_addr", 32'(we_a), 32'(ah[ai]));
          chk("rnd_data", 32'(we_d), 32'(dh[ai]));
        end else begin
          drops++;
        end
        last = ai;
        we_cnt = 0;
        acks++;
        bus.req[ai] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && !bus.ack[i] && $urandom_range(0, 3) == 0) begin
          ah[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          dh[i] = DW'($urandom);
          set_req(i, ah[i], dh[i]);
        end
      end
      hist[cyc % 64] = bus.req;
    end
    chk("rnd_progress", 32'(acks > 100), 32'd1);
    chk("rnd_drop_cnt", 32'(bus.dropCnt), (drops > 255) ? 32'd255 : 32'(drops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
